cs: RTL and testbench

CS -- requirements
Module: cs

---
 rtl/cs.sv | 109 ++++++++++
 tb/tb_cs.sv | 108 ++++++++++
 2 files changed

// File: rtl/cs.sv
// cs: nine-sample smoothing filter.
// Holds a sliding window of the last nine unsigned 8-bit samples. Each cycle
// it takes the window sum S, the truncated mean Xavg = floor(S/9), and the
// largest window entry not above that mean (Xappr). It then outputs
// Y = floor((S + 9*Xappr)/8).
// Y is registered. It is computed from the incoming sample X together with
// the eight most recent stored samples, which form exactly the window as it
// stands after the edge. The oldest entry W8 therefore never needs its own
// register.
module cs (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] X,
  output logic [9:0] Y
);

  localparam int DATA_W = 8;
  localparam int TAPS   = 9;
  localparam int SUM_W  = 12;   // 9 * 255 = 2295 fits in 12 bits
  localparam int ACC_W  = 13;   // S + 9*Xappr <= 4590 fits in 13 bits
  localparam int OUT_W  = 10;   // 4590 / 8 = 573 fits in 10 bits

  // Reciprocal of 9 scaled by 2^16. For S <= 2295 the rounding error of
  // this constant stays below 0.008, well inside the 1/9 spacing of the
  // quotient steps, so floor(S*RECIP9 >> 16) == floor(S/9) over the whole
  // range.
  localparam int         RECIP_SH = 16;
  localparam logic [12:0] RECIP9  = 13'd7282;

  typedef logic [TAPS-1:0][DATA_W-1:0]   win_t;
  typedef logic [TAPS-2:0][DATA_W-1:0]   hist_t;

  // Stored samples: hist_p0[0] is the newest captured sample (W0 after the
  // edge that captured it), hist_p0[7] the oldest one still needed.
  hist_t             hist_p0;
  logic [OUT_W-1:0]  y_p0;

  // Window as it will stand once the current X is shifted in.
  win_t              win_nxt;
  logic [SUM_W-1:0]  sum_nxt;
  logic [DATA_W-1:0] avg_nxt;
  logic [DATA_W-1:0] appr_nxt;
  logic [OUT_W-1:0]  y_nxt;

  // Exact sum of all nine window entries.
  function automatic logic [SUM_W-1:0] win_sum(input win_t w);
    logic [SUM_W-1:0] s;
    s = '0;
    for (int k = 0; k < TAPS; k++) begin
      s = s + SUM_W'(w[k]);
    end
    return s;
  endfunction

  // floor(s / 9) by multiply-and-shift with the scaled reciprocal.
  function automatic logic [DATA_W-1:0] div9(input logic [SUM_W-1:0] s);
    logic [SUM_W+13-1:0] p;
    p = (SUM_W+13)'(s) * (SUM_W+13)'(RECIP9);
    return DATA_W'(p >> RECIP_SH);
  endfunction

  // Largest window entry that does not exceed avg. Starting the search
  // at zero is safe: the window minimum never exceeds the mean, so at
  // least one entry qualifies and zero is the smallest possible answer.
  // Only values are compared, so duplicates and ties are irrelevant.
  function automatic logic [DATA_W-1:0] approx(input win_t w,
                                               input logic [DATA_W-1:0] avg);
    logic [DATA_W-1:0] best;
    best = '0;
    for (int k = 0; k < TAPS; k++) begin
      if ((w[k] <= avg) && (w[k] > best)) begin
        best = w[k];
      end
    end
    return best;
  endfunction

  // floor((s + 9*a) / 8) at full 13-bit width, truncated by the shift.
  function automatic logic [OUT_W-1:0] smooth(input logic [SUM_W-1:0]  s,
                                              input logic [DATA_W-1:0] a);
    logic [ACC_W-1:0] t;
    t = ACC_W'(s) + (ACC_W'(a) * ACC_W'(TAPS));
    return OUT_W'(t >> 3);
  endfunction

  // Assemble the post-shift window and evaluate the filter on it.
  always_comb begin
    win_nxt  = {hist_p0, X};
    sum_nxt  = win_sum(win_nxt);
    avg_nxt  = div9(sum_nxt);
    appr_nxt = approx(win_nxt, avg_nxt);
    y_nxt    = smooth(sum_nxt, appr_nxt);
  end

  // ---- stage p0: window shift and registered result ----
  // Reset empties the window and forces the all-zero-window result.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_p0 <= '0;
      y_p0    <= '0;
    end else begin
      hist_p0 <= hist_t'(win_nxt);
      y_p0    <= y_nxt;
    end
  end

  assign Y = y_p0;

endmodule

// File: tb/tb_cs.sv
// tb_cs: scoreboard bench for the nine-sample smoothing filter.
// The driver pushes one expected Y per driven cycle. The monitor pops one
// entry per rising edge and compares it with the DUT output.
module tb_cs;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] X = 8'd0;
  logic [9:0] Y;

  cs dut (.clk(clk), .reset(reset), .X(X), .Y(Y));

  always #15 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    exp_q[$];
  string name_q[$];
  int    mw[9];

  // Reference: brute-force evaluation over the model window.
  function automatic int model_y();
    int s, avg, ap;
    s = 0;
    for (int k = 0; k < 9; k++) s += mw[k];
    avg = s / 9;
    ap = 0;
    for (int k = 0; k < 9; k++) if (mw[k] <= avg && mw[k] > ap) ap = mw[k];
    return (s + 9 * ap) / 8;
  endfunction

  // Drive one cycle and push its expected result. A non-negative hand value
  // overrides the model for that cycle.
  task automatic send(input int x, input bit r, input int hand, input string nm);
    int e;
    @(negedge clk);
    X = 8'(x);
    reset = r;
    if (r) begin
      for (int k = 0; k < 9; k++) mw[k] = 0;
    end else begin
      for (int k = 8; k > 0; k--) mw[k] = mw[k-1];
      mw[0] = x;
    end
    e = (hand >= 0) ? hand : model_y();
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: one scoreboard entry retires per rising edge.
  always @(posedge clk) begin
    int    e;
    string n;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (Y !== 10'(e)) begin
        errors++;
        $display("FAIL %s: Y=%0d expected %0d", n, Y, e);
      end
    end
  end

  initial begin
    for (int k = 0; k < 9; k++) mw[k] = 0;

    // Power-on reset for two cycles.
    send(0, 1'b1, 0, "reset0");
    send(0, 1'b1, 0, "reset1");

    // Nine samples of 100.
    for (int i = 0; i < 9; i++) send(100, 1'b0, (i == 8) ? 225 : -1, "const100");
    // Samples 0..8.
    for (int i = 0; i < 9; i++) send(i, 1'b0, (i == 8) ? 9 : -1, "ramp0to8");
    // Nine samples of 255 (full scale).
    for (int i = 0; i < 9; i++) send(255, 1'b0, (i == 8) ? 573 : -1, "full255");
    // Eight zeros then 255.
    for (int i = 0; i < 8; i++) send(0, 1'b0, -1, "zeros");
    send(255, 1'b0, 31, "zeros_then_255");

    // Reset, then the random sliding-window stream with a mid-stream reset.
    send(0, 1'b1, 0, "stream_reset0");
    send(0, 1'b1, 0, "stream_reset1");
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        send($urandom_range(0, 255), 1'b1, 0, "mid_reset0");
        send($urandom_range(0, 255), 1'b1, 0, "mid_reset1");
        send(90, 1'b0, 11, "after_reset_90");
      end else begin
        send($urandom_range(0, 255), 1'b0, -1, "random");
      end
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int c = 0; c < 4 && exp_q.size() > 0; c++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
